// File: rtl/hazard_scoreboard_unit.sv
// Per-register load scoreboard generating the ID-stage stall for N read ports.
// Optional stall statistics counters: HAZARD_STALL_STATS_EN.
module hazard_scoreboard_unit #(
  parameter int NREG       = 32,
  parameter int REG_W      = 5,
  parameter int NUM_RPORTS = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_RPORTS*REG_W-1:0] i_ID_rnum,
  input  logic [NUM_RPORTS-1:0]       i_ID_ren,
  input  logic                        i_EX_memRead,
  input  logic [REG_W-1:0]            i_EX_wnum,
  input  logic                        i_EX_wen,
  input  logic                        i_mem_ready,
  input  logic                        i_flush,
  output logic                        o_stall,
  output logic [NREG-1:0]             o_pending,
  output logic                        o_busy
`ifdef HAZARD_STALL_STATS_EN
  ,
  output logic [31:0]                 o_stall_cycles,
  output logic [31:0]                 o_load_stalls
`endif
);

  localparam int PW = 2**REG_W;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LOAD_LAT);

  if (LOAD_LAT >= 2**CNT_W || NREG > 2**REG_W) begin : g_bad_cfg
    $error("hazard_scoreboard_unit: bad parameter set");
  end

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             ex_load;
  logic [PW-1:0]    pend_ext;

  assign ex_load = i_EX_memRead & i_EX_wen & (i_EX_wnum != '0);

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (i_flush) begin
        cnt_d[r] = '0;
      end else if (i_mem_ready) begin
        // a fresh load re-arms even if the old countdown is still draining
        if (ex_load && i_EX_wnum == REG_W'(r) && LOAD_LAT > 0)
          cnt_d[r] = LAT_C;
        else if (cnt_q[r] != '0)
          cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) o_pending[r] = (cnt_q[r] != '0);
  end

  assign o_busy   = |o_pending;
  assign pend_ext = PW'(o_pending);

  always_comb begin
    logic [REG_W-1:0] rn;
    rn      = '0;
    o_stall = 1'b0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      rn = i_ID_rnum[p*REG_W +: REG_W];
      if (i_ID_ren[p] && rn != '0 &&
          ((ex_load && i_EX_wnum == rn) || pend_ext[rn]))
        o_stall = 1'b1;
    end
  end

`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] load_stalls_q, load_stalls_d;
  logic        stall_prev_q, stall_prev_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    load_stalls_d  = load_stalls_q;
    stall_prev_d   = o_stall;
    if (o_stall && !i_flush && !(&stall_cycles_q))
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (o_stall && !stall_prev_q && !(&load_stalls_q))
      load_stalls_d = load_stalls_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      load_stalls_q  <= '0;
      stall_prev_q   <= 1'b0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      load_stalls_q  <= load_stalls_d;
      stall_prev_q   <= stall_prev_d;
    end
  end

  assign o_stall_cycles = stall_cycles_q;
  assign o_load_stalls  = load_stalls_q;
`endif

endmodule
